fp_operand_issuer: RTL and testbench

Front-end issuer for the pipelined floating-point add/subtract datapath. It accepts packed IEEE-754 single-precision operand pairs over a ready/valid handshake and buffers them in a small FIFO. Each pair is unpacked into the mantissa/exponent/mode form the adder pipeline consumes, with operands swapped so the larger magnitude is first. The result sign and special-case flags travel through a delay line matched to the adder latency, so they line up with the adder's exponent/mantissa output.

---
 rtl/fp_operand_issuer.sv | 206 ++++++++++++++++++++
 tb/tb_fp_operand_issuer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_issuer.sv
// Operand issuer for the pipelined FP add/sub datapath: FIFO-buffered IEEE-754 pairs are
// unpacked and magnitude-ordered; sign/flags ride a delay line matched to the adder latency.
// Define FP_ISSUE_SPECIAL_EN to enable the Inf/NaN/zero special-case flag on res_special.
module fp_operand_issuer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic                       in_op,
    input  logic                       hold,
    output logic [22:0]                a,
    output logic [7:0]                 p,
    output logic [22:0]                b,
    output logic [7:0]                 q,
    output logic                       m,
    output logic                       issue_valid,
    output logic                       res_valid,
    output logic                       res_sign,
    output logic                       res_special,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: a pair transfers at a rising edge when in_valid && in_ready; in_ready depends
    // only on occupancy, so a full FIFO refuses even when a pop happens on the same edge.
    logic              push;
    logic              pop;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [64:0]       fifo_mem_q [DEPTH];

    logic [31:0]       ent_a;
    logic [31:0]       ent_b;
    logic              ent_op;
    logic [30:0]       mag_a;
    logic [30:0]       mag_b;
    logic              swap;
    logic              eff_add;
    logic              sign_calc;

    logic [22:0]       a_q, a_d;
    logic [7:0]        p_q, p_d;
    logic [22:0]       b_q, b_d;
    logic [7:0]        q_q, q_d;
    logic              m_q, m_d;
    logic              issue_valid_q, issue_valid_d;
    logic              sign_q, sign_d;

    logic [LATENCY-1:0] dly_valid_q, dly_valid_d;
    logic [LATENCY-1:0] dly_sign_q, dly_sign_d;

    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !hold;

    assign {ent_a, ent_b, ent_op} = fifo_mem_q[rd_ptr_q];
    assign mag_a = ent_a[30:0];
    assign mag_b = ent_b[30:0];

    always_comb begin
        swap      = (mag_b > mag_a);
        eff_add   = ~(ent_a[31] ^ ent_b[31] ^ ent_op);
        sign_calc = ent_a[31];
        // Exact cancellation yields +0; otherwise the larger operand decides the sign.
        if ((mag_a == mag_b) && !eff_add) begin
            sign_calc = 1'b0;
        end else if (swap) begin
            sign_calc = ent_op ? ~ent_b[31] : ent_b[31];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        a_d           = a_q;
        p_d           = p_q;
        b_d           = b_q;
        q_d           = q_q;
        m_d           = m_q;
        sign_d        = sign_q;
        issue_valid_d = pop;
        if (pop) begin
            a_d    = swap ? ent_b[22:0]  : ent_a[22:0];
            p_d    = swap ? ent_b[30:23] : ent_a[30:23];
            b_d    = swap ? ent_a[22:0]  : ent_b[22:0];
            q_d    = swap ? ent_a[30:23] : ent_b[30:23];
            m_d    = eff_add;
            sign_d = sign_calc;
        end
    end

    always_comb begin
        dly_valid_d    = '0;
        dly_sign_d     = '0;
        dly_valid_d[0] = issue_valid_q;
        dly_sign_d[0]  = sign_q;
        for (int i = 1; i < LATENCY; i++) begin
            dly_valid_d[i] = dly_valid_q[i-1];
            dly_sign_d[i]  = dly_sign_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {in_a, in_b, in_op};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            a_q           <= '0;
            p_q           <= '0;
            b_q           <= '0;
            q_q           <= '0;
            m_q           <= 1'b0;
            issue_valid_q <= 1'b0;
            sign_q        <= 1'b0;
            dly_valid_q   <= '0;
            dly_sign_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            a_q           <= a_d;
            p_q           <= p_d;
            b_q           <= b_d;
            q_q           <= q_d;
            m_q           <= m_d;
            issue_valid_q <= issue_valid_d;
            sign_q        <= sign_d;
            dly_valid_q   <= dly_valid_d;
            dly_sign_q    <= dly_sign_d;
        end
    end

`ifdef FP_ISSUE_SPECIAL_EN
    logic               special_calc;
    logic               special_q, special_d;
    logic [LATENCY-1:0] dly_special_q, dly_special_d;

    // Inf/NaN on either side, or a true zero on either side.
    assign special_calc = (ent_a[30:23] == 8'hFF) || (ent_b[30:23] == 8'hFF) ||
                          (mag_a == '0) || (mag_b == '0);

    always_comb begin
        special_d = pop ? special_calc : special_q;
        dly_special_d    = '0;
        dly_special_d[0] = special_q;
        for (int i = 1; i < LATENCY; i++) begin
            dly_special_d[i] = dly_special_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            special_q     <= 1'b0;
            dly_special_q <= '0;
        end else begin
            special_q     <= special_d;
            dly_special_q <= dly_special_d;
        end
    end

    assign res_special = dly_special_q[LATENCY-1];
`else
    assign res_special = 1'b0;
`endif

    assign a           = a_q;
    assign p           = p_q;
    assign b           = b_q;
    assign q           = q_q;
    assign m           = m_q;
    assign issue_valid = issue_valid_q;
    assign res_valid   = dly_valid_q[LATENCY-1];
    assign res_sign    = dly_sign_q[LATENCY-1];
    assign count       = count_q;

endmodule

// File: tb/tb_fp_operand_issuer.sv
// Bench for fp_operand_issuer: directed scenarios plus randomized traffic against a queue-based
// reference model; honours FP_ISSUE_SPECIAL_EN for the special-flag expectations.
module tb_fp_operand_issuer;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 4;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_op = 1'b0;
  logic        hold = 1'b0;
  logic [22:0] a;
  logic [7:0]  p;
  logic [22:0] b;
  logic [7:0]  q;
  logic        m;
  logic        issue_valid;
  logic        res_valid;
  logic        res_sign;
  logic        res_special;
  logic [$clog2(DEPTH):0] count;

  fp_operand_issuer #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .hold(hold),
    .a(a), .p(p), .b(b), .q(q), .m(m), .issue_valid(issue_valid),
    .res_valid(res_valid), .res_sign(res_sign), .res_special(res_special), .count(count)
  );

  // reference model state
  typedef struct { logic [31:0] x; logic [31:0] y; logic op; } pair_t;
  typedef struct { logic v; logic s; logic sp; } res_t;

  pair_t       exp_q[$];
  res_t        hist[$];
  logic [22:0] e_a, e_b;
  logic [7:0]  e_p, e_q;
  logic        e_m, e_iv;
  bit          armed = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge();
    int          occ;
    bit          do_push, do_pop, sw;
    int unsigned mx, my;
    pair_t       e;
    res_t        r;
    if (rst) begin
      exp_q.delete();
      hist.delete();
      for (int i = 0; i <= LATENCY; i++) hist.push_back('{1'b0, 1'b0, 1'b0});
      e_a = '0; e_b = '0; e_p = '0; e_q = '0; e_m = 1'b0; e_iv = 1'b0;
      armed = 1;
      return;
    end
    if (!armed) return;
    occ     = exp_q.size();
    do_push = in_valid && (occ < DEPTH);
    do_pop  = (occ > 0) && !hold;
    r = '{1'b0, 1'b0, 1'b0};
    if (do_pop) begin
      e  = exp_q.pop_front();
      mx = {1'b0, e.x[30:0]};
      my = {1'b0, e.y[30:0]};
      sw = (my > mx);
      e_a = sw ? e.y[22:0] : e.x[22:0];
      e_p = sw ? e.y[30:23] : e.x[30:23];
      e_b = sw ? e.x[22:0] : e.y[22:0];
      e_q = sw ? e.x[30:23] : e.y[30:23];
      e_m = ((e.x[31] ^ e.y[31] ^ e.op) == 1'b0);
      r.v = 1'b1;
      if (mx == my && !e_m) r.s = 1'b0;
      else if (sw) r.s = e.op ? ~e.y[31] : e.y[31];
      else r.s = e.x[31];
`ifdef FP_ISSUE_SPECIAL_EN
      r.sp = (e.x[30:23] == 8'hFF) || (e.y[30:23] == 8'hFF) || (mx == 0) || (my == 0);
`else
      r.sp = 1'b0;
`endif
    end
    if (do_push) exp_q.push_back('{in_a, in_b, in_op});
    e_iv = do_pop;
    hist.push_back(r);
    void'(hist.pop_front());
  endtask

  // one clock: model the edge, then compare every output 1ns later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (armed) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      check("issue_valid", 32'(issue_valid), 32'(e_iv));
      check("a", 32'(a), 32'(e_a));
      check("p", 32'(p), 32'(e_p));
      check("b", 32'(b), 32'(e_b));
      check("q", 32'(q), 32'(e_q));
      check("m", 32'(m), 32'(e_m));
      check("res_valid", 32'(res_valid), 32'(hist[0].v));
      if (hist[0].v) begin
        check("res_sign", 32'(res_sign), 32'(hist[0].s));
        check("res_special", 32'(res_special), 32'(hist[0].sp));
      end
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic o, input logic h);
    in_valid = v; in_a = x; in_b = y; in_op = o; hold = h;
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic o, input logic [22:0] xa, input logic [7:0] xp,
                          input logic [22:0] xb, input logic [7:0] xq, input logic xm,
                          input logic xs, input logic xsp);
    drive(1'b1, x, y, o, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    check({tag, "_iv"}, 32'(issue_valid), 32'd1);
    check({tag, "_a"}, 32'(a), 32'(xa));
    check({tag, "_p"}, 32'(p), 32'(xp));
    check({tag, "_b"}, 32'(b), 32'(xb));
    check({tag, "_q"}, 32'(q), 32'(xq));
    check({tag, "_m"}, 32'(m), 32'(xm));
    repeat (LATENCY) step();
    check({tag, "_rv"}, 32'(res_valid), 32'd1);
    check({tag, "_rs"}, 32'(res_sign), 32'(xs));
    check({tag, "_rsp"}, 32'(res_special), 32'(xsp));
    step();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 7))
      0: v[30:0] = '0;
      1: v[30:23] = 8'hFF;
      2: v[30:23] = 8'h7F;
      default: ;
    endcase
    return v;
  endfunction

  logic spec_exp;
  logic [31:0] rx, ry;

  initial begin
`ifdef FP_ISSUE_SPECIAL_EN
    spec_exp = 1'b1;
`else
    spec_exp = 1'b0;
`endif
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_iv", 32'(issue_valid), 32'd0);
    check("rst_rv", 32'(res_valid), 32'd0);
    rst = 1'b0;
    step();

    directed("basic_add", 32'h3F800000, 32'h40000000, 1'b0,
             23'h0, 8'h80, 23'h0, 8'h7F, 1'b1, 1'b0, 1'b0);
    directed("mixed_sign", 32'hC0400000, 32'h3F800000, 1'b0,
             23'h400000, 8'h80, 23'h0, 8'h7F, 1'b0, 1'b1, 1'b0);
    directed("sub_swap", 32'h3F800000, 32'h40000000, 1'b1,
             23'h0, 8'h80, 23'h0, 8'h7F, 1'b0, 1'b1, 1'b0);
    directed("spec_inf", 32'h7F800000, 32'h3F800000, 1'b0,
             23'h0, 8'hFF, 23'h0, 8'h7F, 1'b1, 1'b0, spec_exp);
    directed("spec_zero", 32'h00000000, 32'h3F800000, 1'b0,
             23'h0, 8'h7F, 23'h0, 8'h00, 1'b1, 1'b0, spec_exp);
    directed("cancel", 32'h40400000, 32'h40400000, 1'b1,
             23'h400000, 8'h80, 23'h400000, 8'h80, 1'b0, 1'b0, 1'b0);

    // FIFO fill under hold, refused fifth offer, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 1'b1);
      step();
    end
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
    step();
    check("full_refuse", 32'(count), 32'(DEPTH));
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check("drain_iv", 32'(issue_valid), 32'd1);
    end
    step();
    check("drain_count", 32'(count), 32'd0);
    check("drain_ready", 32'(in_ready), 32'd1);
    check("drain_gap", 32'(issue_valid), 32'd0);
    repeat (LATENCY) step();

    // reset with results in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_iv", 32'(issue_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < LATENCY + 3; i++) begin
      step();
      check("mid_rst_rv", 32'(res_valid), 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rx = rand_fp();
      ry = ($urandom_range(0, 5) == 0) ? {1'($urandom_range(0, 1)), rx[30:0]} : rand_fp();
      drive(1'($urandom_range(0, 3) != 0), rx, ry, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) == 0));
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (DEPTH + LATENCY + 2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
